// File: rtl/pifo_pkg.sv
// Shared defaults and entry layout for the rank-sink PIFO.
// The top is parameterised; these are the default widths used by the design and its users.
package pifo_pkg;

  localparam int RANK_W_DEF  = 16;
  localparam int META_W_DEF  = 16;
  localparam int L2_DEPTH_DEF = 4;
  localparam int DEPTH_DEF   = 1 << L2_DEPTH_DEF;

  typedef struct packed {
    logic                  valid;
    logic [RANK_W_DEF-1:0] rank;
    logic [META_W_DEF-1:0] meta;
  } pifo_entry_t;

endpackage

// File: rtl/pifo_insert_pos.sv
// Combinational insert-position finder: counts occupied slots whose rank is <= rank_in.
// Because slots are kept sorted and packed from slot 0, the compare vector is a thermometer code.
module pifo_insert_pos
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_W_DEF,
  parameter int L2_DEPTH   = L2_DEPTH_DEF
) (
  input  logic [(1<<L2_DEPTH)-1:0] slot_valid,
  input  logic [RANK_WIDTH-1:0]    slot_rank [1<<L2_DEPTH],
  input  logic [RANK_WIDTH-1:0]    rank_in,
  output logic [L2_DEPTH:0]        pos
);

  localparam int DEPTH = 1 << L2_DEPTH;

  logic [DEPTH-1:0] le;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign le[gi] = slot_valid[gi] & (slot_rank[gi] <= rank_in);
  end

  // Position of the first zero in the thermometer; DEPTH when every slot qualifies.
  always_comb begin
    pos = (L2_DEPTH+1)'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!le[i]) pos = (L2_DEPTH+1)'(i);
    end
  end

endmodule

// File: rtl/pifo_rank_sink.sv
// Consumer of the rank pipe: pops {rank, meta} into a register-based PIFO sorted by ascending rank
// (FIFO among equal ranks) and presents the lowest-rank entry on the dequeue port.
module pifo_rank_sink
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_W_DEF,
  parameter int META_WIDTH = META_W_DEF,
  parameter int L2_DEPTH   = L2_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rank_valid,
  input  logic [RANK_WIDTH-1:0] rank_in,
  input  logic [META_WIDTH-1:0] meta_in,
  output logic                  rank_remove,
  input  logic                  deq_req,
  output logic                  deq_valid,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic [L2_DEPTH:0]     count,
  output logic                  full
);

  localparam int DEPTH = 1 << L2_DEPTH;
  localparam int CW    = L2_DEPTH + 1;

  logic [DEPTH-1:0]      valid_q;
  logic [RANK_WIDTH-1:0] rank_q [DEPTH];
  logic [META_WIDTH-1:0] meta_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  reset_seen_q, reset_seen_d;
  logic                  deq_fire, ins_fire;
  logic [CW-1:0]         pos;

  pifo_insert_pos #(
    .RANK_WIDTH (RANK_WIDTH),
    .L2_DEPTH   (L2_DEPTH)
  ) u_insert_pos (
    .slot_valid (valid_q),
    .slot_rank  (rank_q),
    .rank_in    (rank_in),
    .pos        (pos)
  );

  // Popping is held off until one clock edge has passed out of reset.
  assign deq_fire    = deq_req & valid_q[0];
  assign full        = (count_q == CW'(DEPTH));
  assign ins_fire    = reset_seen_q & rank_valid & (~full | deq_fire);
  assign rank_remove = ins_fire;
  assign deq_valid   = valid_q[0];
  assign deq_rank    = rank_q[0];
  assign deq_meta    = meta_q[0];
  assign count       = count_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam logic [CW-1:0] IDX  = CW'(gi);
    localparam logic [CW-1:0] IDX1 = CW'(gi + 1);

    logic                  v_prev, v_next, v_d, v_q;
    logic [RANK_WIDTH-1:0] r_prev, r_next, r_d, r_q;
    logic [META_WIDTH-1:0] m_prev, m_next, m_d, m_q;

    if (gi > 0) begin : g_prev
      assign v_prev = valid_q[gi-1];
      assign r_prev = rank_q[gi-1];
      assign m_prev = meta_q[gi-1];
    end else begin : g_prev_none
      assign v_prev = 1'b0;
      assign r_prev = '0;
      assign m_prev = '0;
    end

    // The top slot shifts in zeros, which clears it on a dequeue.
    if (gi < DEPTH - 1) begin : g_next
      assign v_next = valid_q[gi+1];
      assign r_next = rank_q[gi+1];
      assign m_next = meta_q[gi+1];
    end else begin : g_next_none
      assign v_next = 1'b0;
      assign r_next = '0;
      assign m_next = '0;
    end

    always_comb begin
      v_d = v_q;
      r_d = r_q;
      m_d = m_q;
      unique case ({ins_fire, deq_fire})
        2'b10: begin
          if (IDX == pos) begin
            v_d = 1'b1; r_d = rank_in; m_d = meta_in;
          end else if (IDX > pos) begin
            v_d = v_prev; r_d = r_prev; m_d = m_prev;
          end
        end
        2'b01: begin
          v_d = v_next; r_d = r_next; m_d = m_next;
        end
        2'b11: begin
          if (pos == '0) begin
            if (IDX == '0) begin
              v_d = 1'b1; r_d = rank_in; m_d = meta_in;
            end
          end else if (IDX1 < pos) begin
            v_d = v_next; r_d = r_next; m_d = m_next;
          end else if (IDX1 == pos) begin
            v_d = 1'b1; r_d = rank_in; m_d = meta_in;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v_q <= 1'b0;
        r_q <= '0;
        m_q <= '0;
      end else begin
        v_q <= v_d;
        r_q <= r_d;
        m_q <= m_d;
      end
    end

    assign valid_q[gi] = v_q;
    assign rank_q[gi]  = r_q;
    assign meta_q[gi]  = m_q;
  end

  always_comb begin
    count_d      = count_q;
    reset_seen_d = 1'b1;
    if (ins_fire && !deq_fire) begin
      count_d = count_q + CW'(1);
    end else if (deq_fire && !ins_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q      <= '0;
      reset_seen_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      reset_seen_q <= reset_seen_d;
    end
  end

endmodule

// File: tb/tb_pifo_rank_sink.sv
// Randomised and directed bench for pifo_rank_sink: a sorted-queue reference model feeds a
// scoreboard of expected dequeues that an independent monitor checks.
module tb_pifo_rank_sink;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rank_valid = 1'b0;
  logic [15:0] rank_in = '0;
  logic [15:0] meta_in = '0;
  logic        rank_remove;
  logic        deq_req = 1'b0;
  logic        deq_valid;
  logic [15:0] deq_rank;
  logic [15:0] deq_meta;
  logic [4:0]  count;
  logic        full;

  pifo_rank_sink #(
    .RANK_WIDTH (16),
    .META_WIDTH (16),
    .L2_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rank_valid  (rank_valid),
    .rank_in     (rank_in),
    .meta_in     (meta_in),
    .rank_remove (rank_remove),
    .deq_req     (deq_req),
    .deq_valid   (deq_valid),
    .deq_rank    (deq_rank),
    .deq_meta    (deq_meta),
    .count       (count),
    .full        (full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] m;
  } ent_t;

  ent_t model[$];
  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare against the model, then advance the model.
  task automatic cycle(input bit rv, input logic [15:0] r, input logic [15:0] m,
                       input bit dq, output bit took);
    bit   df;
    bit   inf;
    int   pos;
    ent_t e;
    @(negedge clk);
    rank_valid = rv;
    rank_in    = r;
    meta_in    = m;
    deq_req    = dq;
    #1;
    df  = dq && (model.size() > 0);
    inf = rv && ((model.size() < DEPTH) || df);
    chk("deq_valid", 32'(deq_valid), 32'(model.size() > 0));
    chk("count", 32'(count), 32'(model.size()));
    chk("full", 32'(full), 32'(model.size() == DEPTH));
    chk("rank_remove", 32'(rank_remove), 32'(inf));
    if (model.size() == 0) chk("empty_head", {deq_rank, deq_meta}, 32'd0);
    if (df) exp_q.push_back(model.pop_front());
    if (inf) begin
      pos = 0;
      while (pos < model.size() && model[pos].r <= r) pos++;
      e.r = r;
      e.m = m;
      model.insert(pos, e);
    end
    took = inf;
    $display("cyc rv=%0b rank=%0d meta=%0h dq=%0b -> remove=%0b count=%0d", rv, r, m, dq, rank_remove, count);
  endtask

  task automatic ins(input logic [15:0] r, input logic [15:0] m);
    bit t;
    cycle(1'b1, r, m, 1'b0, t);
  endtask

  task automatic drain(input int n);
    bit t;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, t);
  endtask

  // Reset asserted away from any edge; released just after a falling edge so the first
  // post-release cycle can confirm that popping waits for a clock edge.
  task automatic reset_pulse();
    @(negedge clk);
    rank_valid = 1'b1;
    rank_in    = 16'd42;
    meta_in    = 16'hbeef;
    deq_req    = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_remove", 32'(rank_remove), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_remove_held", 32'(rank_remove), 32'd0);
    chk("rst_head", {deq_rank, deq_meta}, 32'd0);
    model.delete();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst_remove", 32'(rank_remove), 32'd0);
    $display("reset pulse done");
  endtask

  // Monitor: pops an expected entry whenever the DUT presents a fired dequeue.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (resetn && deq_valid && deq_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected actual=%0d/%0h required=none", deq_rank, deq_meta);
        end else begin
          e = exp_q.pop_front();
          chk("deq_rank", 32'(deq_rank), 32'(e.r));
          chk("deq_meta", 32'(deq_meta), 32'(e.m));
          $display("deq rank=%0d meta=%0h", deq_rank, deq_meta);
        end
      end
    end
  end

  initial begin
    bit          t;
    bit          have_head;
    logic [15:0] hr, hm;

    reset_pulse();

    // Basic ordering
    ins(16'd5, 16'h0105);
    ins(16'd3, 16'h0103);
    ins(16'd9, 16'h0109);
    drain(4);

    // Ties stay FIFO, metadata preserved
    ins(16'd7, 16'haaaa);
    ins(16'd7, 16'hbbbb);
    ins(16'd2, 16'hcccc);
    drain(4);

    // Fill, then blocked, then insert alongside a dequeue
    for (int i = 0; i < DEPTH; i++) ins(16'($urandom_range(0, 1000)), 16'($urandom));
    cycle(1'b1, 16'd500, 16'h5005, 1'b0, t);
    cycle(1'b1, 16'd500, 16'h5005, 1'b0, t);
    cycle(1'b1, 16'd500, 16'h5005, 1'b1, t);
    drain(DEPTH + 1);

    // Simultaneous insert and dequeue from {4,8}
    ins(16'd4, 16'h0004);
    ins(16'd8, 16'h0008);
    cycle(1'b1, 16'd1, 16'h0001, 1'b1, t);
    drain(3);
    ins(16'd4, 16'h0004);
    ins(16'd8, 16'h0008);
    cycle(1'b1, 16'd10, 16'h000a, 1'b1, t);
    drain(3);

    // Empty with dequeue requests
    drain(20);

    // Reset mid-stream
    for (int i = 0; i < 6; i++) ins(16'($urandom_range(0, 50)), 16'($urandom));
    reset_pulse();
    ins(16'd12, 16'h0c0c);
    ins(16'd6, 16'h0606);
    ins(16'd12, 16'h0c0d);
    drain(4);

    // Randomised traffic with pipe-head semantics: a presented head persists until popped
    have_head = 1'b0;
    hr = '0;
    hm = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!have_head && ($urandom_range(0, 9) < 7)) begin
        have_head = 1'b1;
        hr = 16'($urandom_range(0, 31));
        hm = 16'($urandom);
      end
      cycle(have_head, hr, hm, ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 6)), t);
      if (t) have_head = 1'b0;
    end
    drain(DEPTH + 2);

    @(negedge clk);
    #3;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
